// File: rtl/logic_issue_stage_if.sv
// Handshake bundle for the logical-op issue stage: upstream decode fields in,
// head-of-queue operands and queue status out.
interface logic_issue_stage_if #(
    parameter int N = 32
);
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [5:0]     in_opcode;
    logic [5:0]     in_funct;
    logic [N-1:0]   in_rs_val;
    logic [N-1:0]   in_rt_val;
    logic [15:0]    in_imm;
    logic [4:0]     in_dst;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_a;
    logic [N-1:0]   out_b;
    logic [1:0]     out_op;
    logic [4:0]     out_dst;
    logic           out_illegal;
    logic [1:0]     occupancy;

    modport master (
        output flush, in_valid, in_opcode, in_funct, in_rs_val, in_rt_val,
               in_imm, in_dst, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_op, out_dst,
               out_illegal, occupancy
    );

    modport slave (
        input  flush, in_valid, in_opcode, in_funct, in_rs_val, in_rt_val,
               in_imm, in_dst, out_ready,
        output in_ready, out_valid, out_a, out_b, out_op, out_dst,
               out_illegal, occupancy
    );
endinterface

// File: rtl/logic_issue_stage.sv
// Decodes MIPS logical instructions into A/B/op at push time and buffers the
// decoded entries in a 2-deep valid/ready queue feeding the logical unit.
module logic_issue_stage #(
    parameter int N = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    logic_issue_stage_if.slave  bus
);
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [1:0]   op;
        logic [4:0]   dst;
        logic         illegal;
    } entry_t;

    entry_t     dec_d;
    entry_t     head;
    entry_t     mem_q [2];
    logic [1:0] vld_q, vld_d;
    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       rdy_q;
    logic       push, pop;

    // NOTE: every field gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        dec_d     = '0;
        dec_d.dst = bus.in_dst;
        unique case (bus.in_opcode)
            6'h00: begin
                if (bus.in_funct inside {6'h24, 6'h25, 6'h26, 6'h27}) begin
                    dec_d.a  = bus.in_rs_val;
                    dec_d.b  = bus.in_rt_val;
                    dec_d.op = bus.in_funct[1:0];
                end else begin
                    dec_d.illegal = 1'b1;
                end
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dec_d.a  = bus.in_rs_val;
                dec_d.b  = {{(N-16){1'b0}}, bus.in_imm};
                dec_d.op = (bus.in_opcode == 6'h0C) ? OP_AND :
                           (bus.in_opcode == 6'h0D) ? OP_OR  : OP_XOR;
            end
            6'h0F: begin
                dec_d.b[31:16] = bus.in_imm;
                dec_d.op       = OP_OR;
            end
            default: dec_d.illegal = 1'b1;
        endcase
    end

    // rdy_q holds in_ready low during reset and for the edge after release.
    assign bus.in_ready  = rdy_q && (count_q != 2'd2);
    assign bus.out_valid = vld_q[rd_ptr_q];
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        if (bus.flush) begin
            count_d  = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            vld_d    = '0;
        end else begin
            if (push) begin
                vld_d[wr_ptr_q] = 1'b1;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                vld_d[rd_ptr_q] = 1'b0;
                rd_ptr_d        = ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            vld_q    <= '0;
            rdy_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            vld_q    <= vld_d;
            rdy_q    <= 1'b1;
        end
    end

    // NOTE: the entry storage has no reset; valid bits are reset instead and
    // the head is gated by out_valid, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            mem_q[wr_ptr_q] <= dec_d;
        end
    end

    assign head            = bus.out_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.out_a       = head.a;
    assign bus.out_b       = head.b;
    assign bus.out_op      = head.op;
    assign bus.out_dst     = head.dst;
    assign bus.out_illegal = head.illegal;
    assign bus.occupancy   = count_q;
endmodule

// File: tb/tb_logic_issue_stage.sv
// Self-checking bench for logic_issue_stage: vector table of decoded results,
// a queue-based scoreboard checked every cycle, and hand-written corner cases.
module tb_logic_issue_stage;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic_issue_stage_if #(.N(N)) bus ();

    logic_issue_stage #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [4:0]  dst;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [4:0]  dst;
        logic        ill;
    } exp_t;

    vec_t vecs [10];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    bit   ready_m = 1'b0;
    int   cur = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int i);
        cur           = i;
        bus.in_valid  = 1'b1;
        bus.in_opcode = vecs[i].opcode;
        bus.in_funct  = vecs[i].funct;
        bus.in_rs_val = vecs[i].rs;
        bus.in_rt_val = vecs[i].rt;
        bus.in_imm    = vecs[i].imm;
        bus.in_dst    = vecs[i].dst;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // Called at posedge+1 with inputs set: samples mid-cycle, updates the
    // scoreboard from the model's own handshake view, then advances one edge.
    task automatic step();
        bit   exp_rdy, do_push, do_pop;
        exp_t e;
        #3;
        exp_rdy = ready_m && (sb.size() != 2);
        check("in_ready", bus.in_ready, exp_rdy);
        check("out_valid", bus.out_valid, sb.size() != 0);
        check("occupancy", bus.occupancy, sb.size());
        if (sb.size() == 0) begin
            check("empty_ab", {bus.out_a, bus.out_b}, 0);
            check("empty_tag", {bus.out_op, bus.out_dst, bus.out_illegal}, 0);
        end else begin
            check("head_a", bus.out_a, sb[0].a);
            check("head_b", bus.out_b, sb[0].b);
            check("head_op", bus.out_op, sb[0].op);
            check("head_dst", bus.out_dst, sb[0].dst);
            check("head_illegal", bus.out_illegal, sb[0].ill);
        end
        do_pop  = rst_n && !bus.flush && (sb.size() != 0) && bus.out_ready;
        do_push = rst_n && !bus.flush && bus.in_valid && exp_rdy;
        if (do_pop) void'(sb.pop_front());
        if (do_push) begin
            e.a   = vecs[cur].a;
            e.b   = vecs[cur].b;
            e.op  = vecs[cur].op;
            e.dst = vecs[cur].dst;
            e.ill = vecs[cur].ill;
            sb.push_back(e);
        end
        if (!rst_n || bus.flush) sb.delete();
        @(posedge clk);
        ready_m = rst_n;
        #1;
    endtask

    initial begin
        //         opcode funct  rs            rt            imm      dst    a             b             op     ill
        vecs[0] = '{6'h00, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 16'h0000, 5'd1,  32'hF0F0F0F0, 32'h0FF00FF0, 2'b00, 1'b0};
        vecs[1] = '{6'h00, 6'h25, 32'h12345678, 32'h87654321, 16'h0000, 5'd2,  32'h12345678, 32'h87654321, 2'b01, 1'b0};
        vecs[2] = '{6'h00, 6'h26, 32'hAAAA5555, 32'hFFFF0000, 16'h0000, 5'd3,  32'hAAAA5555, 32'hFFFF0000, 2'b10, 1'b0};
        vecs[3] = '{6'h00, 6'h27, 32'h0000FFFF, 32'h00FF00FF, 16'h0000, 5'd7,  32'h0000FFFF, 32'h00FF00FF, 2'b11, 1'b0};
        vecs[4] = '{6'h0C, 6'h00, 32'hCAFEBABE, 32'h11111111, 16'hFFFF, 5'd4,  32'hCAFEBABE, 32'h0000FFFF, 2'b00, 1'b0};
        vecs[5] = '{6'h0D, 6'h00, 32'h11111111, 32'h22222222, 16'h8001, 5'd5,  32'h11111111, 32'h00008001, 2'b01, 1'b0};
        vecs[6] = '{6'h23, 6'h27, 32'hDEADBEEF, 32'h00000001, 16'h0055, 5'd9,  32'h00000000, 32'h00000000, 2'b00, 1'b1};
        vecs[7] = '{6'h0F, 6'h00, 32'hDEADBEEF, 32'h33333333, 16'h1234, 5'd10, 32'h00000000, 32'h12340000, 2'b01, 1'b0};
        vecs[8] = '{6'h0E, 6'h00, 32'hFFFF0000, 32'h44444444, 16'h00FF, 5'd11, 32'hFFFF0000, 32'h000000FF, 2'b10, 1'b0};
        vecs[9] = '{6'h00, 6'h20, 32'h55555555, 32'h66666666, 16'h0000, 5'd12, 32'h00000000, 32'h00000000, 2'b00, 1'b1};

        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_funct  = '0;
        bus.in_rs_val = '0;
        bus.in_rt_val = '0;
        bus.in_imm    = '0;
        bus.in_dst    = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset and release: in_ready stays low until the first edge after release.
        step();
        rst_n = 1'b1;
        step();
        step();

        // Table: each vector pushed alone, then popped.
        for (int i = 0; i < 10; i++) begin
            bus.out_ready = 1'b1;
            drive(i);
            step();
            idle();
            step();
        end

        // Backpressure: third push refused until the cycle after the first pop.
        bus.out_ready = 1'b0;
        drive(0); step();
        drive(1); step();
        drive(2);
        check("bp_full_refuses", bus.in_ready, 1'b0);
        step();
        bus.out_ready = 1'b1;
        check("bp_ready_at_first_pop", bus.in_ready, 1'b0);
        step();
        check("bp_ready_after_pop", bus.in_ready, 1'b1);
        step();
        idle();
        step();
        step();
        check("bp_drained", bus.occupancy, 2'd0);

        // Streaming at one per cycle with an illegal opcode in the mix.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(i);
            step();
            if (i > 0) check("stream_occupancy", bus.occupancy, 2'd1);
        end
        idle();
        step();
        step();

        // Flush with a simultaneous push and pop request.
        bus.out_ready = 1'b0;
        drive(3); step();
        drive(4); step();
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        drive(5);
        step();
        bus.flush = 1'b0;
        idle();
        check("flush_occupancy", bus.occupancy, 2'd0);
        check("flush_out_valid", bus.out_valid, 1'b0);
        step();

        // Asynchronous reset mid-stream with two entries queued.
        bus.out_ready = 1'b0;
        drive(7); step();
        drive(8); step();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 1'b0);
        check("arst_occupancy", bus.occupancy, 2'd0);
        check("arst_in_ready", bus.in_ready, 1'b0);
        check("arst_outputs", {bus.out_a, bus.out_b}, 0);
        sb.delete();
        ready_m = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        bus.out_ready = 1'b1;
        drive(6); step();
        idle(); step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
